// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared encodings, FSM states and status width for datapath_mc (DATAPATH_STATUS_EXT_EN selects {V,N,Z} status)
package datapath_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_NOT = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_PASS = 2'b00,
        SH_LSL  = 2'b01,
        SH_LSR  = 2'b10,
        SH_ASR  = 2'b11
    } shift_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4
    } state_e;

`ifdef DATAPATH_STATUS_EXT_EN
    // status = {V, N, Z}
    localparam int STATUS_W = 3;
`else
    // status = Z only
    localparam int STATUS_W = 1;
`endif

endpackage

// File: rtl/datapath_regfile.sv
// rtl/datapath_regfile.sv - NREGS x WIDTH register file, one sync write port, two async read ports
module datapath_regfile #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int RAW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_we,
    input  logic [RAW-1:0]   i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [RAW-1:0]   i_raddr_a,
    output logic [WIDTH-1:0] o_rdata_a,
    input  logic [RAW-1:0]   i_raddr_b,
    output logic [WIDTH-1:0] o_rdata_b
);

    logic [WIDTH-1:0] r_mem [NREGS];

    // Storage: cleared on reset, written on the clock edge when enabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/datapath_mc.sv
// rtl/datapath_mc.sv - multi-cycle datapath top: FSM, operand latches, shifter, ALU, C/status (DATAPATH_STATUS_EXT_EN adds V/N flags)
module datapath_mc
    import datapath_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int NREGS = 8,
    localparam int RAW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [RAW-1:0]      readnum_a,
    input  logic [RAW-1:0]      readnum_b,
    input  logic [RAW-1:0]      writenum,
    input  logic                write,
    input  logic                vsel,
    input  logic                asel,
    input  logic                bsel,
    input  logic [1:0]          shift,
    input  logic [1:0]          ALUop,
    input  logic [WIDTH-1:0]    datapath_in,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    datapath_out,
    output logic [STATUS_W-1:0] status
);

    state_e r_state;
    state_e w_next_state;

    logic w_ld_cmd;
    logic w_ld_a;
    logic w_ld_b;
    logic w_ld_c;
    logic w_wb;

    // Command captured at start; the controller may change its inputs afterwards
    logic [RAW-1:0]   r_ra;
    logic [RAW-1:0]   r_rb;
    logic [RAW-1:0]   r_wn;
    logic             r_write;
    logic             r_vsel;
    logic             r_asel;
    logic             r_bsel;
    shift_op_e        r_shift;
    alu_op_e          r_aluop;
    logic [WIDTH-1:0] r_imm;

    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_c;
    logic [STATUS_W-1:0] r_status;

    logic [WIDTH-1:0]    w_rd_a;
    logic [WIDTH-1:0]    w_rd_b;
    logic [WIDTH-1:0]    w_bsh;
    logic [WIDTH-1:0]    w_ain;
    logic [WIDTH-1:0]    w_bin;
    logic [WIDTH-1:0]    w_alu;
    logic [STATUS_W-1:0] w_flags;
    logic                w_we;
    logic [WIDTH-1:0]    w_wdata;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state: only IDLE waits, every other state advances unconditionally
    always_comb begin
        w_next_state = ST_IDLE;
        case (r_state)
            ST_IDLE:   w_next_state = start ? ST_LOAD_A : ST_IDLE;
            ST_LOAD_A: w_next_state = ST_LOAD_B;
            ST_LOAD_B: w_next_state = ST_EXEC;
            ST_EXEC:   w_next_state = ST_WB;
            ST_WB:     w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs: per-state load strobes plus busy/done
    always_comb begin
        w_ld_cmd = 1'b0;
        w_ld_a   = 1'b0;
        w_ld_b   = 1'b0;
        w_ld_c   = 1'b0;
        w_wb     = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy     = 1'b0;
                w_ld_cmd = start;
            end
            ST_LOAD_A: w_ld_a = 1'b1;
            ST_LOAD_B: w_ld_b = 1'b1;
            ST_EXEC:   w_ld_c = 1'b1;
            ST_WB: begin
                w_wb = 1'b1;
                done = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    // Command latch, loaded only on the IDLE start edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ra    <= '0;
            r_rb    <= '0;
            r_wn    <= '0;
            r_write <= 1'b0;
            r_vsel  <= 1'b0;
            r_asel  <= 1'b0;
            r_bsel  <= 1'b0;
            r_shift <= SH_PASS;
            r_aluop <= ALU_ADD;
            r_imm   <= '0;
        end else if (w_ld_cmd) begin
            r_ra    <= readnum_a;
            r_rb    <= readnum_b;
            r_wn    <= writenum;
            r_write <= write;
            r_vsel  <= vsel;
            r_asel  <= asel;
            r_bsel  <= bsel;
            r_shift <= shift_op_e'(shift);
            r_aluop <= alu_op_e'(ALUop);
            r_imm   <= datapath_in;
        end
    end

    // Operand latches A/B, result C and status; C and status hold between ops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_status <= '0;
        end else begin
            if (w_ld_a) r_a <= w_rd_a;
            if (w_ld_b) r_b <= w_rd_b;
            if (w_ld_c) begin
                r_c      <= w_alu;
                r_status <= w_flags;
            end
        end
    end

    // Shifter on the B operand
    always_comb begin
        w_bsh = r_b;
        case (r_shift)
            SH_PASS: w_bsh = r_b;
            SH_LSL:  w_bsh = {r_b[WIDTH-2:0], 1'b0};
            SH_LSR:  w_bsh = {1'b0, r_b[WIDTH-1:1]};
            SH_ASR:  w_bsh = {r_b[WIDTH-1], r_b[WIDTH-1:1]};
            default: w_bsh = r_b;
        endcase
    end

    assign w_ain = r_asel ? '0 : r_a;
    assign w_bin = r_bsel ? r_imm : w_bsh;

    // ALU; carry out is dropped by truncation to WIDTH
    always_comb begin
        w_alu = '0;
        case (r_aluop)
            ALU_ADD: w_alu = w_ain + w_bin;
            ALU_SUB: w_alu = w_ain - w_bin;
            ALU_AND: w_alu = w_ain & w_bin;
            ALU_NOT: w_alu = ~w_bin;
            default: w_alu = '0;
        endcase
    end

`ifdef DATAPATH_STATUS_EXT_EN
    logic w_ovf;

    // Flags {V, N, Z}; V is signed overflow for add/sub only
    always_comb begin
        w_ovf = 1'b0;
        case (r_aluop)
            ALU_ADD: w_ovf = (w_ain[WIDTH-1] == w_bin[WIDTH-1]) && (w_alu[WIDTH-1] != w_ain[WIDTH-1]);
            ALU_SUB: w_ovf = (w_ain[WIDTH-1] != w_bin[WIDTH-1]) && (w_alu[WIDTH-1] != w_ain[WIDTH-1]);
            default: w_ovf = 1'b0;
        endcase
        w_flags = {w_ovf, w_alu[WIDTH-1], (w_alu == '0)};
    end
`else
    // Zero flag only
    always_comb begin
        w_flags = (w_alu == '0);
    end
`endif

    assign w_we    = w_wb & r_write;
    assign w_wdata = r_vsel ? r_imm : r_c;

    datapath_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .RAW   (RAW)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .i_we      (w_we),
        .i_waddr   (r_wn),
        .i_wdata   (w_wdata),
        .i_raddr_a (r_ra),
        .o_rdata_a (w_rd_a),
        .i_raddr_b (r_rb),
        .o_rdata_b (w_rd_b)
    );

    assign datapath_out = r_c;
    assign status       = r_status;

endmodule
